// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// ALU/mux selects and the decoded control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_CMPEX    = 4'd12,
    S_UNUSED13 = 4'd13,
    S_UNUSED14 = 4'd14,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BBT   = 6'b111111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_CMP   = 6'b111110;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_CMP   = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // pc_write is unconditional here; the top gates it with the memory handshake
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_word_t;

endpackage

// File: rtl/mc_controller_outdec.sv
// Combinational state-to-control-word decode for the multicycle controller.
module mc_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_req   = 1'b1;
        cw.pc_write  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALU_ADD;
        cw.pc_src    = PC_ALU;
      end
      S_DECODE: begin
        cw.alu_src_b = SRCB_IMM_SH2;
        cw.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        cw.mem_req = 1'b1;
        cw.iord    = 1'b1;
      end
      S_MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_req   = 1'b1;
        cw.iord      = 1'b1;
        cw.mem_write = 1'b1;
      end
      S_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALU_FUNCT;
      end
      S_CMPEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALU_CMP;
      end
      S_ALUWB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALU_SUB;
        cw.pc_src    = PC_ALUOUT;
        cw.branch    = 1'b1;
      end
      S_ADDIWB: cw.reg_write = 1'b1;
      S_JUMP: begin
        cw.pc_src   = PC_JUMP;
        cw.pc_write = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: state register, next-state logic, handshake
// gating of the fetch strobes and the PCEn combine.
module mc_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       InstrDone,
  output logic       Halt,
  output logic [3:0] State
);

  state_t     state;
  state_t     next_state;
  ctrl_word_t cw;
  logic       mem_wait;
  logic       pc_write;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_HALT;
    case (state)
      S_FETCH:  next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW:   next_state = S_MEMADR;
          OP_RTYPE:       next_state = S_EXEC;
          OP_CMP:         next_state = S_CMPEX;
          OP_BEQ, OP_BBT: next_state = S_BRANCH;
          OP_ADDI:        next_state = S_ADDIEX;
          OP_J:           next_state = S_JUMP;
          default:        next_state = S_HALT;
        endcase
      end
      S_MEMADR: next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_ALUWB;
      S_CMPEX:  next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_ADDIEX: next_state = S_ADDIWB;
      S_ADDIWB: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      default:  next_state = S_HALT;
    endcase
  end

  mc_outdec u_outdec (
    .state (state),
    .cw    (cw)
  );

  // Fetch's PC increment and IR load only commit once memory delivers
  assign mem_wait = cw.mem_req & ~MemReady;
  assign pc_write = cw.pc_write & ~mem_wait;

  always_comb begin
    InstrDone = 1'b0;
    case (state)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: InstrDone = 1'b1;
      S_MEMWR: InstrDone = MemReady;
      default: InstrDone = 1'b0;
    endcase
  end

  assign MemReq   = cw.mem_req;
  assign IorD     = cw.iord;
  assign MemWrite = cw.mem_write;
  assign IRWrite  = (state == S_FETCH) & MemReady;
  assign RegWrite = cw.reg_write;
  assign RegDst   = cw.reg_dst;
  assign MemtoReg = cw.mem_to_reg;
  assign ALUSrcA  = cw.alu_src_a;
  assign ALUSrcB  = cw.alu_src_b;
  assign ALUOp    = cw.alu_op;
  assign PCSrc    = cw.pc_src;
  assign PCEn     = pc_write | (cw.branch & Zero);
  assign Halt     = (state == S_HALT);
  assign State    = state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction state paths and
// output tables with randomized memory stalls and Zero.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       MemReq, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, InstrDone, Halt;
  logic [3:0] State;

  int checks   = 0;
  int failures = 0;

  logic [16:0] obs;
  assign obs = {MemReq, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
                ALUSrcB, ALUOp, PCSrc, PCEn, InstrDone, Halt};

  mc_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .InstrDone(InstrDone), .Halt(Halt), .State(State)
  );

  always #5 clk = ~clk;

  // Expected output word for a state, straight from the per-state output table
  function automatic logic [16:0] exp_out(input int s, input logic mr, input logic z);
    logic req = 0, iord = 0, mw = 0, irw = 0, rw = 0, rd = 0, m2r = 0, sa = 0;
    logic [1:0] sb = 0, aop = 0, pcs = 0;
    logic pcen = 0, done = 0, hlt = 0;
    case (s)
      0:  begin req = 1; sb = 2'b01; irw = mr; pcen = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin req = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin req = 1; iord = 1; mw = 1; done = mr; end
      6:  begin sa = 1; aop = 2'b10; end
      12: begin sa = 1; aop = 2'b11; end
      7:  begin rw = 1; rd = 1; done = 1; end
      8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; pcen = z; done = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: begin rw = 1; done = 1; end
      11: begin pcs = 2'b10; pcen = 1; done = 1; end
      15: hlt = 1;
      default: ;
    endcase
    return {req, iord, mw, irw, rw, rd, m2r, sa, sb, aop, pcs, pcen, done, hlt};
  endfunction

  function automatic int base_latency(input logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b111110, 6'b001000: return 4;
      default: return 3;
    endcase
  endfunction

  // One instruction; stall_data<0 randomizes MemReady and Zero everywhere,
  // otherwise the data access stalls exactly stall_data cycles.
  task automatic run_instr(input logic [5:0] op, input int stall_data, input logic zero_in,
                           output int lat, output int dones, output int stalls);
    int path[$];
    int idx = 0;
    int left = stall_data;
    int s;
    logic mr, memst;
    case (op)
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000000: path = '{0, 1, 6, 7};
      6'b111110: path = '{0, 1, 12, 7};
      6'b000100, 6'b111111: path = '{0, 1, 8};
      6'b001000: path = '{0, 1, 9, 10};
      default:   path = '{0, 1, 11};
    endcase
    lat = 0; dones = 0; stalls = 0;
    while (idx < path.size() && lat < 200) begin
      s = path[idx];
      memst = (s == 0 || s == 3 || s == 5);
      @(negedge clk);
      Op = op;
      if (stall_data < 0) begin
        Zero = 1'($urandom_range(0, 1));
        mr = ($urandom_range(0, 3) != 0);
      end else begin
        Zero = zero_in;
        if (!memst) mr = 1'($urandom_range(0, 1));
        else if (s != 0 && left > 0) begin mr = 1'b0; left--; end
        else mr = 1'b1;
      end
      MemReady = mr;
      #1;
      checks++;
      if (State !== 4'(s)) begin
        failures++;
        $display("FAIL state op=%b cyc=%0d got=%0d exp=%0d", op, lat, State, s);
      end
      checks++;
      if (obs !== exp_out(s, mr, Zero)) begin
        failures++;
        $display("FAIL outputs op=%b state=%0d got=%h exp=%h", op, s, obs, exp_out(s, mr, Zero));
      end
      lat++;
      if (InstrDone === 1'b1) dones++;
      if (memst && !mr) stalls++;
      else idx++;
    end
    if (lat >= 200) begin
      failures++;
      $display("FAIL timeout op=%b", op);
    end
  endtask

  task automatic check_instr(input string name, input logic [5:0] op, input int lat,
                             input int dones, input int stalls);
    checks++;
    if (lat != base_latency(op) + stalls) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=%0d", name, lat, base_latency(op) + stalls);
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL %s instrdone_count got=%0d exp=1", name, dones);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1; MemReady = 0; Zero = 0; Op = 6'b000000;
    @(negedge clk);
    reset = 0;
    #1;
    checks++;
    if (State !== 4'd0 || obs !== exp_out(0, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL reset_idle state=%0d outs=%h exp=%h", State, obs, exp_out(0, 1'b0, 1'b0));
    end
    MemReady = 1; #1;
    checks++;
    if (PCEn !== 1'b1 || IRWrite !== 1'b1 || obs !== exp_out(0, 1'b1, 1'b0)) begin
      failures++;
      $display("FAIL reset_ready outs=%h exp=%h", obs, exp_out(0, 1'b1, 1'b0));
    end
    MemReady = 0;
  endtask

  task automatic test_lw;
    int lat, dones, stalls;
    run_instr(6'b100011, 0, 1'b0, lat, dones, stalls);
    checks++;
    if (lat != 5) begin failures++; $display("FAIL lw_latency got=%0d exp=5", lat); end
    check_instr("lw", 6'b100011, lat, dones, stalls);
  endtask

  task automatic test_sw_stall;
    int lat, dones, stalls;
    run_instr(6'b101011, 3, 1'b0, lat, dones, stalls);
    checks++;
    if (lat != 7) begin failures++; $display("FAIL sw_stall_latency got=%0d exp=7", lat); end
    check_instr("sw_stall", 6'b101011, lat, dones, stalls);
  endtask

  task automatic test_branch;
    int lat, dones, stalls;
    logic [5:0] ops [2] = '{6'b000100, 6'b111111};
    for (int i = 0; i < 2; i++)
      for (int z = 0; z < 2; z++) begin
        run_instr(ops[i], 0, 1'(z), lat, dones, stalls);
        checks++;
        if (PCEn !== 1'(z) || PCSrc !== 2'b01) begin
          failures++;
          $display("FAIL branch op=%b zero=%0d pcen=%b pcsrc=%b", ops[i], z, PCEn, PCSrc);
        end
        check_instr("branch", ops[i], lat, dones, stalls);
      end
  endtask

  task automatic test_alu_ops;
    int lat, dones, stalls;
    logic [5:0] ops [4] = '{6'b111110, 6'b000000, 6'b001000, 6'b000010};
    for (int i = 0; i < 4; i++) begin
      run_instr(ops[i], 0, 1'b0, lat, dones, stalls);
      check_instr("alu_op", ops[i], lat, dones, stalls);
    end
  endtask

  task automatic test_reset_mid;
    logic [5:0] seq [4] = '{6'b101011, 6'b101011, 6'b101011, 6'b101011};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      Op = seq[i]; MemReady = (i == 0);
    end
    #1;
    checks++;
    if (State !== 4'd5) begin failures++; $display("FAIL reset_mid_pre state=%0d exp=5", State); end
    reset = 1;
    @(negedge clk);
    reset = 0; MemReady = 0; #1;
    checks++;
    if (State !== 4'd0 || MemWrite !== 1'b0 || MemReq !== 1'b1 || IRWrite !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid state=%0d memwrite=%b memreq=%b exp=0/0/1", State, MemWrite, MemReq);
    end
  endtask

  task automatic test_halt;
    logic mr;
    @(negedge clk); Op = 6'b010101; MemReady = 1;
    @(negedge clk); MemReady = 0; #1;
    checks++;
    if (State !== 4'd1) begin failures++; $display("FAIL halt_decode state=%0d exp=1", State); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mr = 1'($urandom_range(0, 1)); MemReady = mr; Zero = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (State !== 4'd15 || obs !== exp_out(15, mr, Zero)) begin
        failures++;
        $display("FAIL halt_hold cyc=%0d state=%0d outs=%h exp=%h", i, State, obs, exp_out(15, mr, Zero));
      end
    end
    reset = 1;
    @(negedge clk);
    reset = 0; MemReady = 0; #1;
    checks++;
    if (State !== 4'd0 || Halt !== 1'b0 || MemReq !== 1'b1) begin
      failures++;
      $display("FAIL halt_reset state=%0d halt=%b exp=0/0", State, Halt);
    end
  endtask

  task automatic test_random;
    int lat, dones, stalls;
    logic [5:0] ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                            6'b111111, 6'b001000, 6'b000010, 6'b111110};
    logic [5:0] op;
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 7)];
      run_instr(op, -1, 1'b0, lat, dones, stalls);
      check_instr("random", op, lat, dones, stalls);
    end
  endtask

  initial begin
    reset = 1; Op = '0; Zero = 0; MemReady = 0;
    repeat (2) @(posedge clk);
    test_reset;
    test_lw;
    test_sw_stall;
    test_branch;
    test_alu_ops;
    test_reset_mid;
    test_halt;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
